// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
package mem_lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {S_IDLE, S_WRITE} state_t;
endpackage

// File: rtl/lsu_lane_mux.sv
// Little-endian lane steering: load extract/extend and store lane merge.
module lsu_lane_mux
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];

    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: load_data = mem_word;
    endcase

    merge_word = mem_word;
    case (size)
      SZ_BYTE: merge_word[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (lane[1]) merge_word[31:16] = wdata[15:0];
        else         merge_word[15:0]  = wdata[15:0];
      end
      default: merge_word = wdata;
    endcase
  end
endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: sub-word loads, two-cycle registered RMW for
// sub-word stores, access error flags and load/store event counters.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int MEM_AW = 12,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic [31:0]      rdata,
  output logic             stall,
  output logic             misalign_err,
  output logic             range_err,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output logic             DataMemWE,
  output logic [31:0]      DataMemAddr,
  output logic [31:0]      DataMemIn,
  input  logic [31:0]      DataMemOut
);
  state_t      state, state_nxt;
  logic [31:0] merge_q, addr_q;
  logic [31:0] load_data, merge_word;
  logic        active, mis, rng, ok;
  logic        is_load, is_wstore, is_sstore;

  always_comb begin
    active = !rst && (state == S_IDLE) && req_valid;
    mis = (req_size == 2'b11) ||
          ((req_size == SZ_HALF) && req_addr[0]) ||
          ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    rng = |req_addr[31:MEM_AW];
    ok  = active && !mis && !rng;
    is_load   = ok && !req_we;
    is_wstore = ok && req_we && (req_size == SZ_WORD);
    is_sstore = ok && req_we && (req_size != SZ_WORD);
    misalign_err = active && mis;
    range_err    = active && rng;
  end

  lsu_lane_mux u_lane_mux (
    .size        (req_size),
    .lane        (req_addr[1:0]),
    .is_unsigned (req_unsigned),
    .mem_word    (DataMemOut),
    .wdata       (req_wdata),
    .load_data   (load_data),
    .merge_word  (merge_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (is_sstore) state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rdata       = '0;
    stall       = 1'b0;
    DataMemWE   = 1'b0;
    DataMemAddr = '0;
    DataMemIn   = '0;
    case (state)
      S_IDLE: begin
        if (active) DataMemAddr = {req_addr[31:2], 2'b00};
        if (is_load) rdata = load_data;
        if (is_wstore) begin
          DataMemWE = 1'b1;
          DataMemIn = req_wdata;
        end
        if (is_sstore) stall = 1'b1;
      end
      S_WRITE: begin
        DataMemWE   = 1'b1;
        DataMemAddr = addr_q;
        DataMemIn   = merge_q;
      end
      default: ;
    endcase
  end

  // Merge is registered so the memory read never feeds the write data in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      merge_q   <= '0;
      addr_q    <= '0;
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      if (is_sstore) begin
        merge_q <= merge_word;
        addr_q  <= {req_addr[31:2], 2'b00};
      end
      if (is_load) load_cnt <= load_cnt + CNT_W'(1);
      if (is_wstore || (state == S_WRITE)) store_cnt <= store_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu with a word memory and a byte-array reference model.
module tb_mem_lsu;
   localparam int MEM_AW = 12;
   localparam int CNT_W  = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
   logic [1:0]       req_size = 2'b00;
   logic [31:0]      req_addr = '0, req_wdata = '0;
   logic [31:0]      rdata, DataMemAddr, DataMemIn, DataMemOut;
   logic             stall, misalign_err, range_err, DataMemWE;
   logic [CNT_W-1:0] load_cnt, store_cnt;

   logic [31:0] mem [0:1023];
   logic [7:0]  ref_b [0:4095];
   int errors = 0, checks = 0;
   int exp_ld = 0, exp_st = 0;

   always #5 clk = ~clk;

   assign DataMemOut = mem[DataMemAddr[11:2]];
   always @(posedge clk) if (DataMemWE) mem[DataMemAddr[11:2]] <= DataMemIn;

   mem_lsu #(.MEM_AW(MEM_AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rdata(rdata), .stall(stall),
      .misalign_err(misalign_err), .range_err(range_err),
      .load_cnt(load_cnt), .store_cnt(store_cnt), .DataMemWE(DataMemWE),
      .DataMemAddr(DataMemAddr), .DataMemIn(DataMemIn), .DataMemOut(DataMemOut)
   );

   task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
   endtask

   task automatic idle();
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
   endtask

   task automatic wstore(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk); drive(1'b1, 2'b10, 1'b0, a, d);
      @(posedge clk); exp_st++;
   endtask

   task automatic test_reset();
      drive(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
      repeat (3) begin
         @(negedge clk); #1;
         checks++;
         if ({DataMemWE, stall, misalign_err, range_err} !== 4'b0000 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b stall=%b mis=%b rng=%b rdata=%h, want all 0",
                     DataMemWE, stall, misalign_err, range_err, rdata);
         end
         checks++;
         if (load_cnt !== '0 || store_cnt !== '0) begin
            errors++;
            $display("FAIL reset_counters: load=%0d store=%0d, want 0/0", load_cnt, store_cnt);
         end
      end
      @(negedge clk); rst = 1'b0; idle(); #1;
      checks++;
      if (mem[4] !== 32'h0) begin
         errors++;
         $display("FAIL reset_no_write: mem[0x10]=%h, want 0", mem[4]);
      end
      checks++;
      if (DataMemWE !== 1'b0 || stall !== 1'b0 || DataMemAddr !== 32'h0) begin
         errors++;
         $display("FAIL idle_outputs: we=%b stall=%b addr=%h, want 0/0/0", DataMemWE, stall, DataMemAddr);
      end
   endtask

   task automatic test_word_store();
      @(negedge clk); drive(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF); #1;
      checks++;
      if ({DataMemWE, stall} !== 2'b10) begin
         errors++;
         $display("FAIL sw_ctrl: we=%b stall=%b, want 1/0", DataMemWE, stall);
      end
      checks++;
      if (DataMemAddr !== 32'h10 || DataMemIn !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL sw_bus: addr=%h in=%h, want 00000010/deadbeef", DataMemAddr, DataMemIn);
      end
      @(posedge clk); exp_st++;
      @(negedge clk); idle(); #1;
      checks++;
      if (store_cnt !== exp_st[CNT_W-1:0]) begin
         errors++;
         $display("FAIL sw_count: store_cnt=%0d, want %0d", store_cnt, exp_st);
      end
      checks++;
      if (mem[4] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL sw_mem: mem=%h, want deadbeef", mem[4]);
      end
   endtask

   task automatic test_back_to_back();
      wstore(32'h10, 32'h11223344);
      @(negedge clk); drive(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AA); #1;
      checks++;
      if ({stall, DataMemWE} !== 2'b10) begin
         errors++;
         $display("FAIL sb_cycle1: stall=%b we=%b, want 1/0", stall, DataMemWE);
      end
      @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if ({stall, DataMemWE} !== 2'b01 || DataMemAddr !== 32'h10 || DataMemIn !== 32'hAA223344) begin
         errors++;
         $display("FAIL sb_cycle2: stall=%b we=%b addr=%h in=%h, want 0/1/00000010/aa223344",
                  stall, DataMemWE, DataMemAddr, DataMemIn);
      end
      @(posedge clk); exp_st++;
      @(negedge clk); drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0); #1;
      checks++;
      if (rdata !== 32'hAA223344) begin
         errors++;
         $display("FAIL load_after_sb: rdata=%h, want aa223344", rdata);
      end
      @(posedge clk); exp_ld++;
      @(negedge clk); idle(); #1;
      checks++;
      if (store_cnt !== exp_st[CNT_W-1:0] || load_cnt !== exp_ld[CNT_W-1:0]) begin
         errors++;
         $display("FAIL b2b_counts: store=%0d load=%0d, want %0d/%0d", store_cnt, load_cnt, exp_st, exp_ld);
      end
   endtask

   task automatic test_loads();
      logic [1:0]  sz [4] = '{2'b01, 2'b01, 2'b00, 2'b00};
      logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] ad [4] = '{32'h12, 32'h12, 32'h11, 32'h12};
      logic [31:0] ex [4] = '{32'hFFFF8001, 32'h00008001, 32'h00000012, 32'h00000001};
      wstore(32'h10, 32'h80011234);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); drive(1'b0, sz[i], un[i], ad[i], 32'h0); #1;
         checks++;
         if (rdata !== ex[i] || stall !== 1'b0) begin
            errors++;
            $display("FAIL load_%0d: rdata=%h stall=%b, want %h/0", i, rdata, stall, ex[i]);
         end
         @(posedge clk); exp_ld++;
      end
      @(negedge clk); idle(); #1;
      checks++;
      if (load_cnt !== exp_ld[CNT_W-1:0]) begin
         errors++;
         $display("FAIL load_count: load_cnt=%0d, want %0d", load_cnt, exp_ld);
      end
   endtask

   task automatic test_errors();
      logic        we [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [1:0]  sz [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
      logic [31:0] ad [4] = '{32'h11, 32'h1000, 32'h10, 32'h10};
      logic        em [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic        er [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); drive(we[i], sz[i], 1'b0, ad[i], 32'h5A5A5A5A); #1;
         checks++;
         if (misalign_err !== em[i] || range_err !== er[i]) begin
            errors++;
            $display("FAIL err_flags_%0d: mis=%b rng=%b, want %b/%b", i, misalign_err, range_err, em[i], er[i]);
         end
         checks++;
         if (DataMemWE !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL err_effect_%0d: we=%b stall=%b rdata=%h, want 0/0/0", i, DataMemWE, stall, rdata);
         end
         @(posedge clk);
      end
      @(negedge clk); idle(); #1;
      checks++;
      if (store_cnt !== exp_st[CNT_W-1:0] || load_cnt !== exp_ld[CNT_W-1:0]) begin
         errors++;
         $display("FAIL err_counts: store=%0d load=%0d, want %0d/%0d", store_cnt, load_cnt, exp_st, exp_ld);
      end
      checks++;
      if (mem[4] !== 32'h80011234) begin
         errors++;
         $display("FAIL err_mem: mem=%h, want 80011234", mem[4]);
      end
   endtask

   task automatic test_reset_rmw();
      wstore(32'h20, 32'hCAFEF00D);
      @(negedge clk); drive(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000055); #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL rmw_start: stall=%b, want 1", stall);
      end
      @(posedge clk);
      @(negedge clk); rst = 1'b1; #1;
      checks++;
      if (DataMemWE !== 1'b0) begin
         errors++;
         $display("FAIL rmw_reset_we: we=%b, want 0", DataMemWE);
      end
      @(posedge clk);
      @(negedge clk); #1;
      exp_st = 0; exp_ld = 0;
      checks++;
      if (mem[8] !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL rmw_reset_mem: mem=%h, want cafef00d", mem[8]);
      end
      checks++;
      if (store_cnt !== '0 || load_cnt !== '0) begin
         errors++;
         $display("FAIL rmw_reset_counts: store=%0d load=%0d, want 0/0", store_cnt, load_cnt);
      end
      rst = 1'b0; #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL rmw_restart_idle: stall=%b, want 1", stall);
      end
      @(posedge clk);
      @(posedge clk); exp_st++;
      @(negedge clk); idle(); #1;
      checks++;
      if (mem[8] !== 32'hCAFE550D || store_cnt !== exp_st[CNT_W-1:0]) begin
         errors++;
         $display("FAIL rmw_retry: mem=%h store=%0d, want cafe550d/%0d", mem[8], store_cnt, exp_st);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, wd, exp_word, want;
      logic [1:0]  size;
      logic        we, uns, mis, rng;
      longint      v;
      int          n, sel;
      for (int w = 0; w < 1024; w++)
         for (int k = 0; k < 4; k++) ref_b[w*4+k] = mem[w][8*k +: 8];
      for (int it = 0; it < 300; it++) begin
         a = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(MEM_AW, 31));
         sel  = $urandom_range(0, 15);
         size = (sel < 5) ? 2'b00 : (sel < 10) ? 2'b01 : (sel < 15) ? 2'b10 : 2'b11;
         we   = 1'($urandom_range(0, 1));
         uns  = 1'($urandom_range(0, 1));
         wd   = $urandom;
         mis  = (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00);
         rng  = (a >> MEM_AW) != 0;
         n    = 1 << size;
         @(negedge clk); drive(we, size, uns, a, wd); #1;
         checks++;
         if (misalign_err !== mis || range_err !== rng) begin
            errors++;
            $display("FAIL rnd_flags %0d: addr=%h size=%0d mis=%b rng=%b, want %b/%b",
                     it, a, size, misalign_err, range_err, mis, rng);
         end
         if (mis || rng) begin
            checks++;
            if (DataMemWE !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) begin
               errors++;
               $display("FAIL rnd_err %0d: we=%b stall=%b rdata=%h, want 0/0/0", it, DataMemWE, stall, rdata);
            end
            @(posedge clk);
         end else if (!we) begin
            v = 0;
            for (int k = 0; k < n; k++) v = v | (longint'(ref_b[a[11:0] + 12'(k)]) << (8 * k));
            if (!uns && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
            want = v[31:0];
            checks++;
            if (rdata !== want || stall !== 1'b0) begin
               errors++;
               $display("FAIL rnd_load %0d: addr=%h size=%0d uns=%b rdata=%h stall=%b, want %h/0",
                        it, a, size, uns, rdata, stall, want);
            end
            @(posedge clk); exp_ld++;
         end else begin
            for (int k = 0; k < n; k++) ref_b[a[11:0] + 12'(k)] = wd[8*k +: 8];
            for (int k = 0; k < 4; k++) exp_word[8*k +: 8] = ref_b[{a[11:2], 2'b00} + 12'(k)];
            if (size == 2'b10) begin
               checks++;
               if (DataMemWE !== 1'b1 || stall !== 1'b0 || DataMemIn !== exp_word) begin
                  errors++;
                  $display("FAIL rnd_sw %0d: we=%b stall=%b in=%h, want 1/0/%h", it, DataMemWE, stall, DataMemIn, exp_word);
               end
            end else begin
               checks++;
               if (stall !== 1'b1 || DataMemWE !== 1'b0) begin
                  errors++;
                  $display("FAIL rnd_sub1 %0d: stall=%b we=%b, want 1/0", it, stall, DataMemWE);
               end
               @(posedge clk);
               @(negedge clk); #1;
               checks++;
               if (DataMemWE !== 1'b1 || stall !== 1'b0 || DataMemIn !== exp_word ||
                   DataMemAddr !== {a[31:2], 2'b00}) begin
                  errors++;
                  $display("FAIL rnd_sub2 %0d: we=%b stall=%b addr=%h in=%h, want 1/0/%h/%h",
                           it, DataMemWE, stall, DataMemAddr, DataMemIn, {a[31:2], 2'b00}, exp_word);
               end
            end
            @(posedge clk); exp_st++;
         end
      end
      @(negedge clk); idle(); #1;
      checks++;
      if (store_cnt !== exp_st[CNT_W-1:0] || load_cnt !== exp_ld[CNT_W-1:0]) begin
         errors++;
         $display("FAIL rnd_counts: store=%0d load=%0d, want %0d/%0d", store_cnt, load_cnt, exp_st, exp_ld);
      end
      for (int w = 0; w < 16; w++) begin
         for (int k = 0; k < 4; k++) exp_word[8*k +: 8] = ref_b[w*4+k];
         checks++;
         if (mem[w] !== exp_word) begin
            errors++;
            $display("FAIL rnd_mem word %0d: mem=%h, want %h", w, mem[w], exp_word);
         end
      end
   endtask

   initial begin
      for (int w = 0; w < 1024; w++) mem[w] = 32'h0;
      test_reset();
      test_word_store();
      test_back_to_back();
      test_loads();
      test_errors();
      test_reset_rmw();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
